// File: rtl/toggle_rx_pkg.sv
// toggle_rx_pkg: shared types, default sizes and level-width helper for the toggle handshake receiver
package toggle_rx_pkg;
  typedef enum logic {IDLE, STALL} rx_state_t;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH = 4;
  function automatic int LEVEL_W(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/toggle_rx_fifo.sv
// toggle_rx_fifo: power-of-2 FIFO with a registered head word
// Ports: clk, rst (async active-low), push/din write, pop read, full/empty/level status, head = oldest word.
// head holds its last value once the FIFO drains; a push into an empty FIFO appears on head after the edge.
module toggle_rx_fifo
  import toggle_rx_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  logic [DATA_W-1:0]           din,
  output logic                        full,
  output logic                        empty,
  output logic [LEVEL_W(DEPTH)-1:0]   level,
  output logic [DATA_W-1:0]           head
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = LEVEL_W(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
  always_ff @(posedge clk)
    if (push) mem[wr] <= din;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd <= '0;
      wr <= '0;
      level <= '0;
      head <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      level <= level + LW'(push) - LW'(pop);
      // next head after a pop: the stored successor, else the word arriving this edge, else keep the old one
      if (pop) head <= (level > LW'(1)) ? mem[rd + 1'b1] : push ? din : head;
      else if (empty && push) head <= din;
    end
endmodule

// File: rtl/toggle_handshake_receiver.sv
// toggle_handshake_receiver: two-phase toggle handshake receiver feeding a valid/ready FIFO
// Ports: clk, rst (async active-low); req_toggle/req_data from transmitter, ack_toggle back;
// out_valid/out_ready/out_data downstream; fifo_level occupancy, rx_count accepted words, proto_err sticky.
module toggle_handshake_receiver
  import toggle_rx_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_toggle,
  input  logic [DATA_W-1:0]           req_data,
  output logic                        ack_toggle,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [LEVEL_W(DEPTH)-1:0]   fifo_level,
  output logic [31:0]                 rx_count,
  output logic                        proto_err
);
  logic [SYNC_STAGES-1:0] sync;
  logic req_prev, ev, pop, push, can_push, full, empty;
  rx_state_t state;
  assign ev = sync[SYNC_STAGES-1] != req_prev;
  assign out_valid = !empty;
  assign pop = !empty && out_ready;
  // a full FIFO still takes a word when the head leaves in the same cycle
  assign can_push = !full || pop;
  // a stalled word is retried only while the transmitter stays quiet; a second toggle drops it
  assign push = (state == IDLE) ? ev && can_push : !ev && can_push;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sync <= '0;
      req_prev <= 1'b0;
      ack_toggle <= 1'b0;
      rx_count <= '0;
      proto_err <= 1'b0;
      state <= IDLE;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], req_toggle};
      req_prev <= sync[SYNC_STAGES-1];
      if (push) begin
        ack_toggle <= !ack_toggle;
        rx_count <= rx_count + 32'd1;
      end
      if (ev && state == STALL) proto_err <= 1'b1;
      state <= (state == IDLE && ev && !can_push) ? STALL : (state == STALL && (ev || can_push)) ? IDLE : state;
    end
  toggle_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .din(req_data),
    .full(full),
    .empty(empty),
    .level(fifo_level),
    .head(out_data)
  );
endmodule

// File: tb/tb_toggle_handshake_receiver.sv
// tb_toggle_handshake_receiver: randomized self-checking bench with a queue-based reference model
module tb_toggle_handshake_receiver;
  localparam int DATA_W = 8;
  localparam int DEPTH = 4;
  localparam int S = 2;
  logic clk = 0, rst, req_toggle, out_ready, ack_toggle, out_valid, proto_err;
  logic [DATA_W-1:0] req_data, out_data;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [31:0] rx_count;
  int n_chk = 0, n_fail = 0;
  bit rnd = 0;
  bit h[$];
  logic [DATA_W-1:0] mq[$];
  bit m_ack, m_st, m_err;
  logic [31:0] m_cnt;
  logic [DATA_W-1:0] m_head;

  toggle_handshake_receiver #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .req_toggle(req_toggle), .req_data(req_data), .ack_toggle(ack_toggle),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .fifo_level(fifo_level),
    .rx_count(rx_count), .proto_err(proto_err));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // Model: a toggle sampled at edge k-S differing from the one at k-S-1 is an event at edge k.
  always @(posedge clk or negedge rst) begin : mdl
    bit ev, pop, can, acc;
    if (!rst) begin
      h.delete();
      for (int i = 0; i <= S; i++) h.push_back(1'b0);
      mq.delete();
      m_ack = 0; m_st = 0; m_err = 0; m_cnt = 0; m_head = '0;
    end else begin
      ev = h[1] != h[0];
      h.push_back(req_toggle);
      void'(h.pop_front());
      pop = mq.size() > 0 && out_ready;
      can = mq.size() < DEPTH || pop;
      acc = 0;
      if (ev && m_st) begin m_err = 1; m_st = 0; end
      else if (ev) begin if (can) acc = 1; else m_st = 1; end
      else if (m_st && can) begin acc = 1; m_st = 0; end
      if (pop) void'(mq.pop_front());
      if (acc) begin mq.push_back(req_data); m_ack = !m_ack; m_cnt++; end
      if (mq.size() > 0) m_head = mq[0];
    end
  end

  always @(negedge clk)
    if (rst) begin
      chk("m_ack", ack_toggle, m_ack);
      chk("m_valid", out_valid, mq.size() > 0);
      chk("m_data", out_data, m_head);
      chk("m_level", fifo_level, mq.size());
      chk("m_count", rx_count, m_cnt);
      chk("m_err", proto_err, m_err);
    end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input int bound, input bit exp);
    logic a0;
    bit got;
    a0 = ack_toggle;
    req_data = d;
    req_toggle = !req_toggle;
    got = 0;
    for (int i = 0; i < bound && !got; i++) begin
      tick();
      got = ack_toggle != a0;
    end
    chk("send_ack", got, exp);
  endtask

  initial begin
    logic a0;
    rst = 0; req_toggle = 0; req_data = '0; out_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    repeat (10) begin
      tick();
      chk("idle_ack", ack_toggle, 0);
      chk("idle_valid", out_valid, 0);
      chk("idle_count", rx_count, 0);
      chk("idle_data", out_data, 0);
    end
    req_data = 8'hA5;
    req_toggle = 1;
    tick(); tick();
    chk("lat_ack_early", ack_toggle, 0);
    chk("lat_valid_early", out_valid, 0);
    tick();
    chk("single_ack", ack_toggle, 1);
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, 8'hA5);
    chk("single_count", rx_count, 1);
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("pop_valid", out_valid, 0);
    chk("pop_level", fifo_level, 0);
    chk("pop_hold", out_data, 8'hA5);
    for (int i = 1; i <= 4; i++) send(8'(i), 10, 1);
    chk("fill_level", fifo_level, 4);
    send(8'h05, 10, 0);
    chk("stall_level", fifo_level, 4);
    chk("stall_count", rx_count, 5);
    a0 = ack_toggle;
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("stall_ack", ack_toggle, !a0);
    chk("stall_swap_level", fifo_level, 4);
    chk("stall_head", out_data, 8'h02);
    chk("stall_swap_count", rx_count, 6);
    send(8'h06, 10, 0);
    a0 = ack_toggle;
    req_toggle = !req_toggle;
    repeat (6) tick();
    chk("perr_flag", proto_err, 1);
    chk("perr_ack", ack_toggle, a0);
    chk("perr_level", fifo_level, 4);
    chk("perr_count", rx_count, 6);
    out_ready = 1;
    repeat (6) tick();
    chk("drain_level", fifo_level, 0);
    send(8'h77, 10, 1);
    chk("legal_count", rx_count, 7);
    chk("perr_sticky", proto_err, 1);
    out_ready = 0;
    rst = 0; req_toggle = 0;
    #1 chk("rst_err", proto_err, 0);
    tick();
    rst = 1;
    tick();
    out_ready = 1;
    for (int i = 0; i < 20; i++) send(8'($urandom), 10, 1);
    repeat (4) tick();
    chk("stream_count", rx_count, 20);
    chk("stream_err", proto_err, 0);
    chk("stream_level", fifo_level, 0);
    rnd = 1;
    for (int i = 0; i < 40; i++) begin
      send(8'($urandom), 80, 1);
      repeat ($urandom_range(0, 2)) tick();
    end
    rnd = 0;
    out_ready = 1;
    repeat (10) tick();
    chk("rand_count", rx_count, 60);
    chk("rand_level", fifo_level, 0);
    chk("rand_err", proto_err, 0);
    out_ready = 0;
    for (int i = 1; i <= 3; i++) send(8'(8'h40 + i), 10, 1);
    chk("mid_level", fifo_level, 3);
    rst = 0; req_toggle = 0;
    #1;
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ack", ack_toggle, 0);
    chk("mid_rst_count", rx_count, 0);
    chk("mid_rst_data", out_data, 0);
    tick();
    rst = 1;
    tick();
    send(8'h3C, 10, 1);
    chk("post_rst_count", rx_count, 1);
    chk("post_rst_data", out_data, 8'h3C);
    chk("post_rst_level", fifo_level, 1);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
